// File: rtl/alu_master_if.sv
// alu_master_if - system bus seen by the ALU job sequencer.
// Carries arbitration (m_req/m_grant), the single-cycle access strobe,
// address/data in both directions and the slave interrupt line.
interface alu_master_if;
  logic        m_req;
  logic        m_grant;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [31:0] m_dout;
  logic [31:0] m_din;
  logic        m_interrupt;

  modport master (
    output m_req, m_wr, m_addr, m_dout,
    input  m_grant, m_din, m_interrupt
  );

  modport slave (
    input  m_req, m_wr, m_addr, m_dout,
    output m_grant, m_din, m_interrupt
  );
endinterface

// File: rtl/alu_master.sv
// alu_master - runs one ALU job on the ALU slave: enable IRQ, load operands,
// write instruction, start, wait for IRQ, read RESULT/ALU_STATUS, clear IRQ.
// Optional watchdog on the interrupt wait: define ALU_MASTER_TIMEOUT_EN.
module alu_master #(
  parameter logic [15:0] BASE_ADDR   = 16'h0200,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [31:0]  cmd_inst,
  input  logic [3:0]   cmd_opcnt,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [31:0]  op_data,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [31:0]  res_data,
  output logic [1:0]   res_status,
  output logic         res_timeout,
  alu_master_if.master bus
);

  // Slave register addresses: offset lives in the low byte of the address.
  localparam logic [15:0] A_START = {BASE_ADDR[15:8], 8'h00};
  localparam logic [15:0] A_INT   = {BASE_ADDR[15:8], 8'h01};
  localparam logic [15:0] A_IE    = {BASE_ADDR[15:8], 8'h02};
  localparam logic [15:0] A_INST  = {BASE_ADDR[15:8], 8'h03};
  localparam logic [15:0] A_RES   = {BASE_ADDR[15:8], 8'h04};
  localparam logic [15:0] A_STAT  = {BASE_ADDR[15:8], 8'h05};

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_W_IE, S_W_OP, S_W_INST, S_W_START, S_WAIT,
    S_REQ2, S_R_RES, S_C_RES, S_C_STAT, S_W_CLR, S_OUT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] res_data_q, res_data_d;
  logic [1:0]  res_status_q, res_status_d;
  logic        cap_q, cap_d;       // RESULT already captured during a C_RES stall

  logic        grant;
  logic        m_req_c, m_wr_c, op_ready_c;
  logic [15:0] m_addr_c;
  logic [31:0] m_dout_c;

  assign grant = bus.m_grant;

`ifdef ALU_MASTER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] W_LIMIT = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic          to_flag_q, to_flag_d;     // this job lost its interrupt
  logic          res_timeout_q, res_timeout_d;
  assign res_timeout = res_timeout_q;
`else
  assign res_timeout = 1'b0;
`endif

  // A zero or negative watchdog limit would make the wait meaningless.
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("alu_master: TIMEOUT_CYC must be at least 1");
  end

  // Bus access decode: an access only happens in a granted cycle.
  always_comb begin
    m_req_c    = 1'b0;
    m_wr_c     = 1'b0;
    m_addr_c   = A_STAT;
    m_dout_c   = 32'h0;
    op_ready_c = 1'b0;
    case (state_q)
      S_REQ, S_REQ2, S_C_STAT: m_req_c = 1'b1;
      S_W_IE: begin
        m_req_c = 1'b1;
        if (grant) begin
          m_wr_c = 1'b1; m_addr_c = A_IE; m_dout_c = 32'h1;
        end
      end
      S_W_OP: begin
        m_req_c = 1'b1;
        if (grant && op_valid) begin
          m_wr_c     = 1'b1;
          m_addr_c   = {BASE_ADDR[15:8], 4'h1, idx_q};
          m_dout_c   = op_data;
          op_ready_c = 1'b1;
        end
      end
      S_W_INST: begin
        m_req_c = 1'b1;
        if (grant) begin
          m_wr_c = 1'b1; m_addr_c = A_INST; m_dout_c = inst_q;
        end
      end
      S_W_START: begin
        m_req_c = 1'b1;
        if (grant) begin
          m_wr_c = 1'b1; m_addr_c = A_START; m_dout_c = 32'h1;
        end
      end
      S_R_RES: begin
        m_req_c = 1'b1;
        if (grant) m_addr_c = A_RES;
      end
      // The ALU_STATUS read uses the idle address, so only m_req matters here.
      S_C_RES: m_req_c = 1'b1;
      S_W_CLR: begin
        m_req_c = 1'b1;
        if (grant) begin
          m_wr_c = 1'b1; m_addr_c = A_INT; m_dout_c = 32'h0;
        end
      end
      default: ;
    endcase
  end

  assign bus.m_req  = m_req_c;
  assign bus.m_wr   = m_wr_c;
  assign bus.m_addr = m_addr_c;
  assign bus.m_dout = m_dout_c;
  assign op_ready   = op_ready_c;
  assign cmd_ready  = (state_q == S_IDLE);
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_status = res_status_q;

  // Job sequencing: next state and next values of the result registers.
  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_status_d = res_status_q;
    cap_d        = cap_q;
`ifdef ALU_MASTER_TIMEOUT_EN
    wcnt_d        = wcnt_q;
    to_flag_d     = to_flag_q;
    res_timeout_d = res_timeout_q;
`endif
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        inst_d  = cmd_inst;
        cnt_d   = cmd_opcnt;
        idx_d   = 4'd0;
        state_d = S_REQ;
      end
      S_REQ:    if (grant) state_d = S_W_IE;
      S_W_IE:   if (grant) state_d = S_W_OP;
      S_W_OP: if (grant && op_valid) begin
        idx_d = idx_q + 4'd1;
        if (idx_q == cnt_q) state_d = S_W_INST;
      end
      S_W_INST: if (grant) state_d = S_W_START;
      S_W_START: if (grant) begin
        state_d = S_WAIT;
`ifdef ALU_MASTER_TIMEOUT_EN
        wcnt_d    = '0;
        to_flag_d = 1'b0;
`endif
      end
      S_WAIT: begin
        if (bus.m_interrupt) begin
          state_d = S_REQ2;
`ifdef ALU_MASTER_TIMEOUT_EN
        end else if (wcnt_q == W_LIMIT) begin
          to_flag_d = 1'b1;
          state_d   = S_REQ2;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
`endif
        end
      end
      S_REQ2: if (grant) begin
`ifdef ALU_MASTER_TIMEOUT_EN
        state_d = to_flag_q ? S_W_CLR : S_R_RES;
`else
        state_d = S_R_RES;
`endif
      end
      S_R_RES: if (grant) begin
        state_d = S_C_RES;
        cap_d   = 1'b0;
      end
      // RESULT arrives on m_din the cycle after its read; capture it once
      // even if the follow-up ALU_STATUS read is stalled by the arbiter.
      S_C_RES: begin
        if (!cap_q) begin
          res_data_d = bus.m_din;
          cap_d      = 1'b1;
        end
        if (grant) state_d = S_C_STAT;
      end
      S_C_STAT: begin
        res_status_d = bus.m_din[1:0];
        state_d      = S_W_CLR;
      end
      S_W_CLR: if (grant) begin
        res_valid_d = 1'b1;
        state_d     = S_OUT;
`ifdef ALU_MASTER_TIMEOUT_EN
        if (to_flag_q) begin
          res_timeout_d = 1'b1;
          res_data_d    = 32'h0;
          res_status_d  = 2'b11;
        end
`endif
      end
      S_OUT: if (res_ready) begin
        res_valid_d = 1'b0;
        state_d     = S_IDLE;
`ifdef ALU_MASTER_TIMEOUT_EN
        res_timeout_d = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset abandons any job in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      inst_q       <= 32'h0;
      cnt_q        <= 4'd0;
      idx_q        <= 4'd0;
      res_valid_q  <= 1'b0;
      res_data_q   <= 32'h0;
      res_status_q <= 2'b00;
      cap_q        <= 1'b0;
`ifdef ALU_MASTER_TIMEOUT_EN
      wcnt_q        <= '0;
      to_flag_q     <= 1'b0;
      res_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_status_q <= res_status_d;
      cap_q        <= cap_d;
`ifdef ALU_MASTER_TIMEOUT_EN
      wcnt_q        <= wcnt_d;
      to_flag_q     <= to_flag_d;
      res_timeout_q <= res_timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_master.sv
// tb_alu_master - directed checks of the ALU job sequencer against a small
// ALU slave model (registered read data, interrupt N cycles after start).
module tb_alu_master;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_inst;
  logic [3:0]  cmd_opcnt;
  logic        op_valid, op_ready;
  logic [31:0] op_data;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [1:0]  res_status;
  logic        res_timeout;

  alu_master_if bus ();

  alu_master #(.BASE_ADDR(16'h0200), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_inst(cmd_inst), .cmd_opcnt(cmd_opcnt),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_status(res_status), .res_timeout(res_timeout),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Slave model
  logic [31:0] slv_result, slv_status;
  int          irq_delay;
  int          irq_cnt;

  always @(posedge clk) begin
    if (reset) begin
      bus.m_interrupt <= 1'b0;
      bus.m_din       <= 32'h0;
      irq_cnt         <= 0;
    end else begin
      bus.m_din <= (bus.m_addr == 16'h0204) ? slv_result :
                   (bus.m_addr == 16'h0205) ? slv_status : 32'h0;
      if (bus.m_wr && bus.m_grant && bus.m_addr == 16'h0200 && bus.m_dout[0])
        irq_cnt <= irq_delay;
      else if (irq_cnt > 0) begin
        irq_cnt <= irq_cnt - 1;
        if (irq_cnt == 1) bus.m_interrupt <= 1'b1;
      end
      if (bus.m_wr && bus.m_grant && bus.m_addr == 16'h0201)
        bus.m_interrupt <= 1'b0;
    end
  end

  // Bus monitor
  typedef struct { logic [15:0] a; logic [31:0] d; int cyc; } wr_t;
  wr_t wlog[$];
  int  cyc_n = 0;
  int  opr_pulses = 0;
  int  bad_acc = 0;
  int  rd_res = 0;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (!reset) begin
      if (bus.m_wr) begin
        wlog.push_back('{bus.m_addr, bus.m_dout, cyc_n});
        if (!bus.m_grant) bad_acc <= bad_acc + 1;
        if (bus.m_addr[7:4] == 4'h1 && !op_valid) bad_acc <= bad_acc + 1;
      end
      if (op_ready) begin
        opr_pulses <= opr_pulses + 1;
        if (!op_valid || !bus.m_grant) bad_acc <= bad_acc + 1;
      end
      if (bus.m_addr == 16'h0204 && bus.m_grant && !bus.m_wr) rd_res <= rd_res + 1;
    end
  end

  logic [31:0] ops [16];
  int wb, pb, bb, rb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int i, input logic [15:0] a, input logic [31:0] d);
    if (wb + i < wlog.size()) begin
      check({tag, "_addr"}, 64'(wlog[wb+i].a), 64'(a));
      check({tag, "_data"}, 64'(wlog[wb+i].d), 64'(d));
    end else
      check({tag, "_missing"}, 64'(wlog.size() - wb), 64'(i + 1));
  endtask

  task automatic mark();
    wb = wlog.size(); pb = opr_pulses; bb = bad_acc; rb = rd_res;
  endtask

  task automatic start_job(input logic [31:0] inst, input logic [3:0] cnt);
    cmd_inst = inst; cmd_opcnt = cnt; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic feed_ops(input int n, input bit toggle, input int gap_idx);
    int  idx = 0;
    int  cyc = 0;
    bit  gapped = 1'b0;
    bit  phase = 1'b0;
    bit  hs;
    while (idx < n && cyc < 400) begin
      if (!gapped && idx == gap_idx) begin
        bus.m_grant = 1'b0; op_valid = 1'b1; op_data = ops[idx];
        repeat (3) @(posedge clk);
        #1;
        bus.m_grant = 1'b1; gapped = 1'b1;
      end
      op_valid = toggle ? phase : 1'b1;
      phase    = ~phase;
      op_data  = ops[idx];
      @(negedge clk);
      hs = op_valid && op_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
    end
    op_valid = 1'b0;
    check("feed_ops_done", 64'(idx), 64'(n));
  endtask

  task automatic wait_res(input int budget);
    int c = 0;
    while (!res_valid && c < budget) begin
      @(posedge clk); #1; c++;
    end
    check("res_valid_seen", 64'(res_valid), 64'(1));
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("res_valid_drop", 64'(res_valid), 64'(0));
    check("cmd_ready_back", 64'(cmd_ready), 64'(1));
  endtask

  task automatic job_basic(input string tag);
    slv_result = 32'h8; slv_status = 32'h2; irq_delay = 4;
    ops[0] = 32'h5; ops[1] = 32'h3;
    mark();
    start_job(32'h0000_0001, 4'd1);
    feed_ops(2, 1'b0, -1);
    wait_res(200);
    check_wr({tag, "_w0"}, 0, 16'h0202, 32'h1);
    check_wr({tag, "_w1"}, 1, 16'h0210, 32'h5);
    check_wr({tag, "_w2"}, 2, 16'h0211, 32'h3);
    check_wr({tag, "_w3"}, 3, 16'h0203, 32'h1);
    check_wr({tag, "_w4"}, 4, 16'h0200, 32'h1);
    check_wr({tag, "_w5"}, 5, 16'h0201, 32'h0);
    check({tag, "_nwr"}, 64'(wlog.size() - wb), 64'(6));
    if (wlog.size() - wb >= 6)
      check({tag, "_irq_lat"}, 64'(wlog[wb+5].cyc - wlog[wb+4].cyc), 64'(10));
    check({tag, "_rd_res"}, 64'(rd_res - rb), 64'(1));
    check({tag, "_res_data"}, 64'(res_data), 64'(32'h8));
    check({tag, "_res_status"}, 64'(res_status), 64'(2));
    check({tag, "_res_timeout"}, 64'(res_timeout), 64'(0));
    check({tag, "_cmd_ready_busy"}, 64'(cmd_ready), 64'(0));
    consume();
  endtask

  initial begin
    logic [31:0] held;
    int          bad_order;
    reset = 1'b1; bus.m_grant = 1'b1;
    cmd_valid = 1'b0; cmd_inst = 32'h0; cmd_opcnt = 4'd0;
    op_valid = 1'b0; op_data = 32'h0; res_ready = 1'b0;
    slv_result = 32'h0; slv_status = 32'h0; irq_delay = 0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_m_req", 64'(bus.m_req), 64'(0));
    check("rst_m_wr", 64'(bus.m_wr), 64'(0));
    check("rst_m_addr", 64'(bus.m_addr), 64'(16'h0205));
    check("rst_m_dout", 64'(bus.m_dout), 64'(0));
    check("rst_op_ready", 64'(op_ready), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_res_data", 64'(res_data), 64'(0));
    check("rst_res_status", 64'(res_status), 64'(0));
    check("rst_res_timeout", 64'(res_timeout), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic two-operand job
    job_basic("basic");
    $display("[TB] job basic: res_data=0x%0h res_status=%0d", res_data, res_status);

    // Sixteen operands with toggling valid, then a held result
    slv_result = 32'hDEAD_BEEF; slv_status = 32'h1; irq_delay = 2;
    for (int i = 0; i < 16; i++) ops[i] = 32'h100 + i;
    mark();
    start_job(32'hA5A5_0002, 4'd15);
    feed_ops(16, 1'b1, -1);
    wait_res(200);
    bad_order = 0;
    for (int i = 0; i < 16; i++)
      if (wb + 1 + i >= wlog.size() || wlog[wb+1+i].a != 16'h0210 + 16'(i) || wlog[wb+1+i].d != ops[i])
        bad_order++;
    check("ops16_order", 64'(bad_order), 64'(0));
    check("ops16_nwr", 64'(wlog.size() - wb), 64'(20));
    check_wr("ops16_inst", 17, 16'h0203, 32'hA5A5_0002);
    check("ops16_op_ready", 64'(opr_pulses - pb), 64'(16));
    check("ops16_bad_acc", 64'(bad_acc - bb), 64'(0));
    check("ops16_res_data", 64'(res_data), 64'(32'hDEAD_BEEF));
    check("ops16_res_status", 64'(res_status), 64'(1));
    held = res_data;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_res_valid", 64'(res_valid), 64'(1));
      check("hold_res_data", 64'(res_data), 64'(held));
      check("hold_cmd_ready", 64'(cmd_ready), 64'(0));
    end
    consume();
    $display("[TB] job ops16: res_data=0x%0h res_status=%0d", res_data, res_status);

    // Grant dropped for three cycles at operand index 2
    slv_result = 32'h1234_5678; slv_status = 32'h0; irq_delay = 3;
    for (int i = 0; i < 4; i++) ops[i] = 32'h200 + i;
    mark();
    start_job(32'h0000_0003, 4'd3);
    feed_ops(4, 1'b0, 2);
    wait_res(200);
    check_wr("gap_op0", 1, 16'h0210, 32'h200);
    check_wr("gap_op2", 3, 16'h0212, 32'h202);
    check_wr("gap_op3", 4, 16'h0213, 32'h203);
    check("gap_op_ready", 64'(opr_pulses - pb), 64'(4));
    check("gap_bad_acc", 64'(bad_acc - bb), 64'(0));
    check("gap_nwr", 64'(wlog.size() - wb), 64'(8));
    check("gap_res_data", 64'(res_data), 64'(32'h1234_5678));
    consume();
    $display("[TB] job gap: res_data=0x%0h res_status=%0d", res_data, res_status);

    // Reset while in W_INST, then a clean job
    irq_delay = 4; ops[0] = 32'h7;
    mark();
    start_job(32'h0000_0004, 4'd0);
    feed_ops(1, 1'b0, -1);
    reset = 1'b1;
    #1;
    check("rstmid_m_req", 64'(bus.m_req), 64'(0));
    check("rstmid_m_wr", 64'(bus.m_wr), 64'(0));
    check("rstmid_cmd_ready", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;
    check("rstmid_m_req_next", 64'(bus.m_req), 64'(0));
    check("rstmid_cmd_ready_next", 64'(cmd_ready), 64'(1));
    check("rstmid_nwr", 64'(wlog.size() - wb), 64'(2));
    reset = 1'b0;
    @(posedge clk); #1;
    job_basic("after_rst");
    $display("[TB] job after reset: res_data=0x%0h res_status=%0d", res_data, res_status);

`ifdef ALU_MASTER_TIMEOUT_EN
    // No interrupt: watchdog expires after 16 WAIT cycles
    irq_delay = 0; slv_result = 32'h55; slv_status = 32'h0; ops[0] = 32'h9;
    mark();
    start_job(32'h0000_0005, 4'd0);
    feed_ops(1, 1'b0, -1);
    wait_res(200);
    check("to_nwr", 64'(wlog.size() - wb), 64'(5));
    check_wr("to_clr", 4, 16'h0201, 32'h0);
    if (wlog.size() - wb >= 5)
      check("to_lat", 64'(wlog[wb+4].cyc - wlog[wb+3].cyc), 64'(18));
    check("to_rd_res", 64'(rd_res - rb), 64'(0));
    check("to_res_timeout", 64'(res_timeout), 64'(1));
    check("to_res_status", 64'(res_status), 64'(3));
    check("to_res_data", 64'(res_data), 64'(0));
    consume();
    check("to_timeout_clear", 64'(res_timeout), 64'(0));
    $display("[TB] job timeout: res_timeout cleared after handshake");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_master.md
Name: alu_master

Overview:
- Bus-master sequencer that drives one complete ALU job through the ALU slave register map.
- Job steps: enable the slave interrupt, load N operands, write the instruction, start the operation, wait for the slave interrupt, read RESULT and ALU_STATUS, then clear the interrupt.
- Sits on the system bus as an arbitrated master (m_req/m_grant). Faces the local engine through valid/ready command, operand and result streams.
- Slave offsets: 0x00 OPERATION_START, 0x01 INTERRUPT, 0x02 INTERRUPT_ENABLE, 0x03 INSTRUCTION, 0x04 RESULT, 0x05 ALU_STATUS, 0x10-0x1F OPERAND_00..15.

Parameters:
- BASE_ADDR, 16'h0200: slave base address; register offset is placed in m_addr[7:0].
- TIMEOUT_CYC, 1024: watchdog limit in cycles while waiting for the interrupt (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  job request
- cmd_ready  out  1  high in IDLE
- cmd_inst  in  32  instruction word
- cmd_opcnt  in  4  operand count minus 1 (0..15 means 1..16 operands)
- op_valid  in  1  operand stream valid
- op_ready  out  1  operand accepted this cycle
- op_data  in  32  operand word
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_data  out  32  RESULT read from slave
- res_status  out  2  ALU_STATUS[1:0] read from slave
- res_timeout  out  1  job aborted by watchdog
- m_req  out  1  bus request
- m_grant  in  1  bus grant
- m_wr  out  1  write strobe
- m_addr  out  16  bus address
- m_dout  out  32  write data
- m_din  in  32  read data (slave-registered)
- m_interrupt  in  1  slave s_interrupt

Behaviour:
- Reset (asynchronous, active-high): state IDLE. m_req=0, m_wr=0, m_addr=BASE_ADDR+0x05, m_dout=0, op_ready=0, res_valid=0, res_data=0, res_status=0, res_timeout=0, operand index=0. cmd_ready=1 (combinational, state==IDLE).
- Non-access cycles: m_wr=0, m_addr=BASE+0x05 (ALU_STATUS is a side-effect-free read), m_dout=0.
- Bus accesses are issued only in cycles with m_grant=1. If m_grant drops mid-job, the FSM stalls in place; no access, counter or stream advance occurs.
- Read latency: the slave registers s_dout on the access edge. Data is sampled from m_din exactly one cycle after the read access cycle.
- States and transitions:
  - IDLE: on cmd_valid, latch cmd_inst and cmd_opcnt -> REQ.
  - REQ: m_req=1. On m_grant -> W_IE.
  - W_IE: write 0x02 <= 1 (one cycle) -> W_OP.
  - W_OP: when op_valid, write 0x10+idx <= op_data with op_ready=1 in the same cycle, then idx++. If op_valid=0, hold with no access. When idx==cnt, the write completes -> W_INST.
  - W_INST: write 0x03 <= inst -> W_START.
  - W_START: write 0x00 <= 1 -> WAIT.
  - WAIT: m_req=0 (bus released). On m_interrupt=1 -> REQ2.
  - REQ2: m_req=1. On grant -> R_RES.
  - R_RES: read 0x04 -> C_RES.
  - C_RES: res_data <= m_din. Also issue read 0x05 in the same cycle -> C_STAT.
  - C_STAT: res_status <= m_din[1:0] -> W_CLR.
  - W_CLR: write 0x01 <= 0. This clears the slave interrupt and OPERATION_START[0] -> OUT.
  - OUT: m_req=0, res_valid=1. On res_ready, res_valid drops the next cycle -> IDLE.
- Simultaneous events:
  - cmd_valid is ignored outside IDLE.
  - An m_interrupt already high on WAIT entry is accepted immediately.
  - res_ready without res_valid has no effect.
- Reset mid-job: immediate return to IDLE with all outputs at reset values. The slave is not cleaned up; its state is the software's responsibility.
- Every stream uses a held-valid handshake: a transfer occurs in a cycle where valid and ready are both 1.

Optional Feature:
- Macro: ALU_MASTER_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT; it is cleared on WAIT entry.
  - On reaching TIMEOUT_CYC with no interrupt -> REQ2, then W_CLR directly (reads skipped).
  - In OUT: res_timeout=1, res_data=0, res_status=2'b11.
  - res_timeout clears when leaving OUT.
- Not defined: WAIT has no limit, and res_timeout is tied to 0.

Test Plan:
- cmd_opcnt=1, operands 0x5, 0x3, inst 0x0000_0001, grant always high, interrupt 4 cycles after start, m_din=0x8 then 0x2 -> exact write sequence (0x202<=1, 0x210<=5, 0x211<=3, 0x203<=1, 0x200<=1), reads 0x204 and 0x205, write 0x201<=0; res_data=0x8, res_status=2.
- cmd_opcnt=15, op_valid toggling every other cycle -> 16 writes to 0x210..0x21F in order; op_ready pulses exactly 16 times; no write in cycles with op_valid=0.
- m_grant dropped for 3 cycles during W_OP idx 2 -> no bus access during the gap; resumes at 0x212; operand count preserved.
- res_ready held low for 5 cycles -> res_valid stays 1 with stable data; cmd_ready=0 until the handshake completes.
- reset pulsed during W_INST -> next cycle m_req=0, m_wr=0, cmd_ready=1; a new job then runs cleanly.
- ALU_MASTER_TIMEOUT_EN defined with TIMEOUT_CYC=16 and no interrupt -> after 16 WAIT cycles: write 0x201<=0, then res_valid=1 with res_timeout=1, res_status=3, res_data=0.
